// File: rtl/pll_lock_reset_sequencer.sv
// PLL supervisor running on the PLL reference clock.
// It pulses the PLL reset, synchronises and debounces lock, releases the
// downstream domain resets one at a time, counts lock losses and flags
// relock timeouts.
//
// state       | meaning
// S_PLL_RST   | PLL held in reset for PLL_RST_CYCLES
// S_WAIT_LOCK | waiting for lock, bounded by RELOCK_TIMEOUT_CYCLES
// S_STABLE    | lock must stay high for LOCK_STABLE_CYCLES
// S_RELEASE   | domain resets released every STAGE_DELAY_CYCLES
// S_RUN       | all domains out of reset, ready asserted
module pll_lock_reset_sequencer #(
  parameter int NUM_DOMAINS           = 4,
  parameter int SYNC_STAGES           = 2,
  parameter int PLL_RST_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES    = 1024,
  parameter int STAGE_DELAY_CYCLES    = 16,
  parameter int RELOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOSS_CNT_WIDTH        = 8
) (
  input  logic                      piul1RefClock,
  input  logic                      piul1Reset_n,
  input  logic                      piul1Locked,
  input  logic                      piul1ForceReset,
  output logic                      poul1PllReset,
  output logic [NUM_DOMAINS-1:0]    poulDomainReset_n,
  output logic                      poul1Ready,
  output logic [LOSS_CNT_WIDTH-1:0] poulLossCount,
  output logic                      poul1Timeout
);

  localparam int REL_CYCLES = NUM_DOMAINS * STAGE_DELAY_CYCLES;
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (RELOCK_TIMEOUT_CYCLES > REL_CYCLES) ? RELOCK_TIMEOUT_CYCLES : REL_CYCLES;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TO_LAST   = CW'(RELOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_REL_DONE  = CW'(REL_CYCLES);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_cnt;
  logic [SYNC_STAGES-1:0]    r_sync;
  logic                      r_pll_rst;
  logic [NUM_DOMAINS-1:0]    r_dom_n;
  logic                      r_ready;
  logic [LOSS_CNT_WIDTH-1:0] r_loss;
  logic                      r_timeout;
  logic                      w_lk;

  assign w_lk = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous lock into the reference clock domain.
  always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) r_sync <= '0;
    else               r_sync <= {r_sync[SYNC_STAGES-2:0], piul1Locked};
  end

  // Sequencing FSM with registered outputs; force request beats lock loss.
  always_ff @(posedge piul1RefClock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_dom_n   <= '0;
      r_ready   <= 1'b0;
      r_loss    <= '0;
      r_timeout <= 1'b0;
    end else if (piul1ForceReset) begin
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_pll_rst <= 1'b1;
      r_dom_n   <= '0;
      r_ready   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == C_PLL_LAST) begin
            r_state   <= S_WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (w_lk) begin
            r_state <= S_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_TO_LAST) begin
            r_state   <= S_PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_STABLE: begin
          if (!w_lk) begin
            // Bounce during debounce is not a loss; relock window restarts.
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == C_STAB_LAST) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!w_lk) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
            r_dom_n <= '0;
            r_ready <= 1'b0;
            if (r_loss != '1) r_loss <= r_loss + 1'b1;
          end else if (r_state == S_RELEASE) begin
            if (r_cnt == C_REL_DONE) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_ready <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_ONE;
              for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (r_cnt == CW'((i + 1) * STAGE_DELAY_CYCLES - 1)) r_dom_n[i] <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state   <= S_PLL_RST;
          r_cnt     <= '0;
          r_pll_rst <= 1'b1;
          r_dom_n   <= '0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign poul1PllReset     = r_pll_rst;
  assign poulDomainReset_n = r_dom_n;
  assign poul1Ready        = r_ready;
  assign poulLossCount     = r_loss;
  assign poul1Timeout      = r_timeout;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: directed scenarios plus random lock
// activity, checked every cycle against a time-since-phase-entry model.
module tb_pll_lock_reset_sequencer;

  localparam int N   = 3;
  localparam int S   = 2;
  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int SDC = 4;
  localparam int RTC = 32;
  localparam int LW  = 2;
  localparam int LOSS_MAX = (1 << LW) - 1;

  localparam int P_PLL  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_REL  = 3;

  logic          clk;
  logic          rst_n;
  logic          locked;
  logic          force_rst;
  logic          pll_rst;
  logic [N-1:0]  dom_n;
  logic          ready;
  logic [LW-1:0] loss;
  logic          timeout;

  int n_chk = 0;
  int n_err = 0;

  // model: phase + cycles since entering it; domains derived arithmetically
  int     m_phase;
  int     m_age;
  int     m_loss;
  bit     m_to;
  bit [S-1:0] m_sync;

  pll_lock_reset_sequencer #(
    .NUM_DOMAINS(N), .SYNC_STAGES(S), .PLL_RST_CYCLES(PRC),
    .LOCK_STABLE_CYCLES(LSC), .STAGE_DELAY_CYCLES(SDC),
    .RELOCK_TIMEOUT_CYCLES(RTC), .LOSS_CNT_WIDTH(LW)
  ) dut (
    .piul1RefClock(clk),
    .piul1Reset_n(rst_n),
    .piul1Locked(locked),
    .piul1ForceReset(force_rst),
    .poul1PllReset(pll_rst),
    .poulDomainReset_n(dom_n),
    .poul1Ready(ready),
    .poulLossCount(loss),
    .poul1Timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int released_domains();
    int k;
    if (m_phase != P_REL) return 0;
    k = m_age / SDC;
    if (k > N) k = N;
    return k;
  endfunction

  function automatic logic [31:0] exp_mask();
    return (32'd1 << released_domains()) - 32'd1;
  endfunction

  task automatic model_reset();
    m_phase = P_PLL;
    m_age   = 0;
    m_loss  = 0;
    m_to    = 1'b0;
    m_sync  = '0;
  endtask

  task automatic model_step();
    bit lk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lk     = m_sync[S-1];
    m_sync = {m_sync[S-2:0], locked};
    if (force_rst) begin
      m_phase = P_PLL;
      m_age   = 0;
      m_to    = 1'b0;
      return;
    end
    case (m_phase)
      P_PLL: begin
        m_age++;
        if (m_age == PRC) begin m_phase = P_WAIT; m_age = 0; end
      end
      P_WAIT: begin
        if (lk) begin
          m_phase = P_STAB; m_age = 0;
        end else begin
          m_age++;
          if (m_age == RTC) begin m_phase = P_PLL; m_age = 0; m_to = 1'b1; end
        end
      end
      P_STAB: begin
        if (!lk) begin
          m_phase = P_WAIT; m_age = 0;
        end else begin
          m_age++;
          if (m_age == LSC) begin m_phase = P_REL; m_age = 0; end
        end
      end
      default: begin
        if (!lk) begin
          if (m_loss < LOSS_MAX) m_loss++;
          m_phase = P_WAIT; m_age = 0;
        end else begin
          m_age++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("pll_rst", 32'(pll_rst), 32'(m_phase == P_PLL));
    check("dom_n",   32'(dom_n),   exp_mask());
    check("ready",   32'(ready),   32'(m_phase == P_REL && m_age > N * SDC));
    check("loss",    32'(loss),    32'(m_loss));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int lim;
    rst_n = 1'b0; locked = 1'b0; force_rst = 1'b0;
    model_reset();
    #12;
    check("rst_pll", 32'(pll_rst), 32'd1);
    check("rst_dom", 32'(dom_n),   32'd0);
    check("rst_rdy", 32'(ready),   32'd0);
    rst_n = 1'b1;

    // relock timeout with lock held low: pulses every PRC+RTC cycles
    run(80);
    check("timeout_set", 32'(timeout), 32'd1);

    // nominal bring-up to RUN
    locked = 1'b1;
    run(40);
    check("nominal_ready", 32'(ready), 32'd1);
    check("nominal_dom",   32'(dom_n), 32'd7);

    // force coincident with synchronised lock falling
    locked = 1'b0;
    run(2);
    force_rst = 1'b1;
    run(1);
    force_rst = 1'b0;
    check("force_pll",  32'(pll_rst), 32'd1);
    check("force_loss", 32'(loss),    32'd0);
    check("force_to",   32'(timeout), 32'd0);

    // debounce: short lock, one-cycle drop, then steady lock
    run(10);
    locked = 1'b1; run(5);
    locked = 1'b0; run(1);
    locked = 1'b1; run(40);
    check("debounce_loss", 32'(loss), 32'd0);

    // repeated lock loss in RUN; counter saturates
    for (int k = 1; k <= 4; k++) begin
      locked = 1'b0; run(4);
      check("loss_cnt", 32'(loss), 32'((k < LOSS_MAX) ? k : LOSS_MAX));
      check("loss_dom", 32'(dom_n), 32'd0);
      locked = 1'b1; run(40);
    end

    // random lock activity with occasional force requests
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        force_rst = 1'b1; run($urandom_range(1, 3)); force_rst = 1'b0;
      end
      locked = 1'b1; run($urandom_range(1, 40));
      locked = 1'b0; run($urandom_range(1, 45));
    end

    // asynchronous reset while two domains are released
    force_rst = 1'b1; run(1); force_rst = 1'b0;
    locked = 1'b1;
    lim = 0;
    while (exp_mask() != 32'd3 && lim < 200) begin cyc(); lim++; end
    check("reach_011", 32'(dom_n), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_pll",  32'(pll_rst), 32'd1);
    check("arst_dom",  32'(dom_n),   32'd0);
    check("arst_rdy",  32'(ready),   32'd0);
    check("arst_loss", 32'(loss),    32'd0);
    check("arst_to",   32'(timeout), 32'd0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(40);
    check("final_ready", 32'(ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_sequencer.md
Name: pll_lock_reset_sequencer

Overview:
- Parametrised PLL supervisor that sits beside the PLL instance and runs on the PLL reference clock.
- Drives the PLL reset and qualifies the asynchronous PLL lock signal.
- Releases NUM_DOMAINS downstream resets in a staggered order once lock is stable; re-sequences on lock loss or software request.
- Adds what the plain PLL wrapper lacks: lock debounce, relock timeout with automatic PLL re-reset, ordered multi-domain reset release, and lock-loss statistics.

Parameters:
- NUM_DOMAINS, 4, number of downstream reset outputs (1..16).
- SYNC_STAGES, 2, synchroniser depth for piul1Locked (>=2).
- PLL_RST_CYCLES, 16, cycles poul1PllReset is held high per PLL reset pulse (>=1).
- LOCK_STABLE_CYCLES, 1024, cycles synchronised lock must stay continuously high before release starts (>=1).
- STAGE_DELAY_CYCLES, 16, spacing between successive domain releases (>=1).
- RELOCK_TIMEOUT_CYCLES, 65536, maximum cycles in WAIT_LOCK before the PLL is reset again (>=1).
- LOSS_CNT_WIDTH, 8, width of the lock-loss counter.

Ports:
- piul1RefClock, in, 1, reference clock; the only clock.
- piul1Reset_n, in, 1, asynchronous active-low reset.
- piul1Locked, in, 1, PLL lock, asynchronous to piul1RefClock.
- piul1ForceReset, in, 1, synchronous request to restart the full sequence.
- poul1PllReset, out, 1, active-high PLL reset.
- poulDomainReset_n, out, NUM_DOMAINS, active-low domain resets; bit 0 is released first.
- poul1Ready, out, 1, high only in RUN.
- poulLossCount, out, LOSS_CNT_WIDTH, saturating count of lock losses.
- poul1Timeout, out, 1, sticky flag: a relock timeout has occurred.

Behaviour:
- Reset values: state PLL_RST, all counters 0, poul1PllReset=1, poulDomainReset_n all 0, poul1Ready=0, poulLossCount=0, poul1Timeout=0. All outputs are registered.
- Lock synchronisation: lk = piul1Locked after SYNC_STAGES flops. The FSM uses only lk.
- PLL_RST:
  - PllReset=1, all domains in reset.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK; PllReset=0 from that cycle.
- WAIT_LOCK:
  - lk=1 goes to STABLE.
  - If the cycle counter reaches RELOCK_TIMEOUT_CYCLES with lk=0: set Timeout, go to PLL_RST.
- STABLE:
  - The counter increments while lk=1.
  - lk=0 goes to WAIT_LOCK. The timeout counter restarts; this is not counted as a loss.
  - Reaching LOCK_STABLE_CYCLES goes to RELEASE.
- RELEASE:
  - A stage counter starts at 0 on entry.
  - DomainReset_n[i] goes high at (i+1)*STAGE_DELAY_CYCLES cycles after entry and stays high.
  - One cycle after the last bit is released, go to RUN.
- RUN: Ready=1; the state holds while lk=1.
- Lock loss (lk=0 in RELEASE or RUN):
  - Next cycle: all DomainReset_n=0 and Ready=0.
  - LossCount increments, saturating at all-ones.
  - Go to WAIT_LOCK. The PLL is not reset.
- ForceReset=1 in any state:
  - Next cycle: state PLL_RST, PllReset=1, all domains in reset, Ready=0, Timeout cleared.
  - LossCount unchanged.
  - ForceReset takes priority over a simultaneous lock loss; no loss increment.
  - While ForceReset is held, remain in PLL_RST with the counter held at 0.
- Asynchronous reset mid-sequence: immediately return to the reset values above, including the synchroniser flops.
- Lock glitches shorter than LOCK_STABLE_CYCLES in STABLE never release any domain.

Test Plan (NUM_DOMAINS=3, SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, STAGE_DELAY_CYCLES=4, RELOCK_TIMEOUT_CYCLES=32, LOSS_CNT_WIDTH=2):
- Nominal bring-up: deassert reset, raise Locked at cycle 10 -> PllReset low after 4 cycles. Release begins 8 cycles after lk rises. DomainReset_n = 001, 011, 111 at +4, +8, +12 from RELEASE entry; Ready at +13.
- Debounce: Locked high 5 cycles, low 1, then high -> no domain released until 8 continuous lk cycles; LossCount stays 0.
- Timeout: Locked held low -> Timeout=1 and PllReset re-asserted 32 cycles after WAIT_LOCK entry; pulse repeats every 36 cycles.
- Lock loss in RUN, repeated 4 times -> all domains asserted the cycle after lk falls; LossCount 1, 2, 3, 3 (saturated); each relock re-sequences 001, 011, 111.
- ForceReset in RUN coincident with Locked falling -> PllReset=1 next cycle, LossCount unchanged, Timeout cleared, full sequence reruns.
- Async reset asserted mid-RELEASE (DomainReset_n=011) -> outputs return to reset values in the same cycle, without waiting for a clock edge.
